// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mul_pkg;

   // Booth digit as one-hot magnitude plus sign: {neg, one, two}
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_dig_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Radix-4 digits needed to cover a WID-bit operand extended by two bits
   function automatic int n_digits(input int wid);
      return (wid + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Operand / product handshake bundle for booth_r4_mul.
interface booth_r4_mul_if #(parameter int WID = 8);
   logic               in_valid;
   logic               in_ready;
   logic               sgn_i;
   logic [WID-1:0]     op1_i;
   logic [WID-1:0]     op2_i;
   logic               out_valid;
   logic               out_ready;
   logic [2*WID-1:0]   prod_o;

   modport master (
      output in_valid, sgn_i, op1_i, op2_i, out_ready,
      input  in_ready, out_valid, prod_o
   );

   modport slave (
      input  in_valid, sgn_i, op1_i, op2_i, out_ready,
      output in_ready, out_valid, prod_o
   );
endinterface

// File: rtl/booth_r4_mul_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {neg, one, two}.
module booth_enc
   import mul_pkg::*;
(
   input  logic [2:0] win_i,
   output booth_dig_t dig_o
);

   // Window {y[2i+1], y[2i], y[2i-1]} selects a digit in -2..+2
   always_comb begin
      dig_o = '0;
      case (win_i)
         3'b001, 3'b010: dig_o.one = 1'b1;
         3'b011:         dig_o.two = 1'b1;
         3'b100:         begin dig_o.neg = 1'b1; dig_o.two = 1'b1; end
         3'b101, 3'b110: begin dig_o.neg = 1'b1; dig_o.one = 1'b1; end
         default:        dig_o = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_mul.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, fixed latency.
module booth_r4_mul
   import mul_pkg::*;
#(
   parameter int WID = 8
) (
   input  logic           clk,
   input  logic           rst,
   booth_r4_mul_if.slave  bus
);

   localparam int N  = n_digits(WID);
   localparam int EW = WID + 2;
   localparam int AW = 2*WID + 4;
   localparam int CW = $clog2(N);

   state_t           state_q, state_d;
   logic [EW-1:0]    x_q;
   logic [EW:0]      y_q;          // y_q[0] is the appended y[-1] = 0
   logic [AW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q;
   logic [2*WID-1:0] prod_q;

   logic [AW-1:0]    x_ext, mag, term;
   logic [2:0]       win;
   booth_dig_t       dig;
   logic             last;

   assign last = (cnt_q == CW'(N-1));
   assign win  = y_q[{cnt_q, 1'b0} +: 3];

   booth_enc u_enc (.win_i(win), .dig_o(dig));

   // Partial product for the current digit, weighted by 4^cnt, added to acc
   always_comb begin
      x_ext = {{(AW-EW){x_q[EW-1]}}, x_q};
      mag   = '0;
      if (dig.two)      mag = x_ext << 1;
      else if (dig.one) mag = x_ext;
      term  = dig.neg ? (~mag + 1'b1) : mag;
      acc_d = acc_q + (term << {cnt_q, 1'b0});
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; in_valid is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = CALC;
         CALC:    if (last)         state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode straight from registered state
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.prod_o    = prod_q;
   end

   // Operand latch, accumulation and product capture
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               x_q   <= {{2{bus.sgn_i & bus.op1_i[WID-1]}}, bus.op1_i};
               y_q   <= {{2{bus.sgn_i & bus.op2_i[WID-1]}}, bus.op2_i, 1'b0};
               acc_q <= '0;
               cnt_q <= '0;
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (last) prod_q <= acc_d[2*WID-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/booth_r4_mul.md
# booth_r4_mul

Iterative radix-4 Booth multiplier, the forward counterpart to the `srt_r2` divider in the `srt_div` arithmetic library. It accepts one WID×WID operand pair through a valid/ready handshake and computes the full 2·WID-bit product, in signed or unsigned mode, over a fixed number of cycles. The result is held on a valid/ready output port. The block sits next to the divider in datapaths that need multiply/divide pairs with matched handshakes.

## Interface
- `WID`, default 8: operand width. Must be even and ≥4.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `sgn_i` input 1: 1 = both operands two's complement; 0 = both unsigned. Sampled with the operands.
- `op1_i` input WID: multiplicand.
- `op2_i` input WID: multiplier.
- `out_valid` output 1: product valid.
- `out_ready` input 1: consumer accepts product.
- `prod_o` output 2·WID: product. Exact in both modes; no overflow is possible.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC on `in_valid && in_ready`. Latch `op1_i`, `op2_i` and `sgn_i`; clear the accumulator and the digit counter.
  - CALC → DONE after the last Booth digit is accumulated.
  - DONE → IDLE on `out_ready`.
- Operand extension:
  - Both operands are extended to WID+2 bits: sign-extended if `sgn_i`=1, zero-extended otherwise.
  - The multiplier gets an appended LSB of 0 (y[-1]=0).
- Digit count N = (WID+2)/2, which is 5 for WID=8. This is fixed regardless of mode, so latency is data-independent.
- Digit i (0..N-1) is selected by {y[2i+1], y[2i], y[2i-1]}:
  - 000, 111 → 0
  - 001, 010 → +1
  - 011 → +2
  - 100 → −2
  - 101, 110 → −1
- Accumulate: acc ← acc + (digit·X) << 2i.
  - acc is 2·WID+4 bits wide.
  - X is the extended multiplicand, sign-extended to acc width.
  - −X is formed as ~X+1; ±2X as X<<1.
- `prod_o` is driven from acc[2·WID-1:0], registered at CALC→DONE. It is stable throughout DONE.
- `in_valid` is ignored in CALC and DONE: no queueing, and operands are not re-sampled.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `prod_o`=0, accumulator 0, counter 0.
- Reset asserted mid-CALC or in DONE: next edge returns to IDLE. The pending result is discarded and `out_valid` drops.

## Timing
- Handshake at edge k. CALC occupies cycles k+1 .. k+N. `out_valid`=1 from cycle k+N+1.
- Latency is N+1 edges, which is 6 for WID=8.
- `out_valid` and `prod_o` hold until `out_ready`=1 is sampled with `out_valid`=1.
  - On that edge the FSM returns to IDLE.
  - `in_ready` is high in the following cycle.
  - Throughput is one result per N+2 cycles with `out_ready` tied high.
- `in_ready` is not combinationally dependent on `out_ready`. There are no combinational input-to-output paths.
- Same-cycle `in_valid` and `out_ready` while in DONE: only the output transfer completes. New operands are accepted no earlier than the next cycle.

## Structure
- Package `mul_pkg`:
  - Booth digit encoding, a 3-bit one-hot {neg, one, two}.
  - State enum: IDLE, CALC, DONE.
  - Helper constant N = (WID+2)/2.
- Sub-module `booth_enc`: combinational 3-bit window → {neg, one, two}. Instantiated once; the window is selected by the digit counter.
- Top `booth_r4_mul` contains the FSM, operand registers, accumulator and counter.

## Test plan
- Signed, op1=0x80, op2=0x80 (−128×−128) → `prod_o`=0x4000, `out_valid` 6 edges after handshake.
- Unsigned, 0xFF×0xFF → 0xFE01. Signed, same operands (−1×−1) → 0x0001.
- Signed, 0xFF×0x7F (−1×127) → 0xFF81. Unsigned, 0x00×0xA5 → 0x0000.
- Back-pressure: `out_ready`=0 for 10 cycles. `prod_o`, `out_valid` stable; `in_ready`=0; new `in_valid` pulses ignored. Result is released on the first `out_ready`=1 edge.
- Reset asserted during the 3rd CALC cycle → next cycle `in_ready`=1, `out_valid`=0, `prod_o`=0. A subsequent 3×5 unsigned multiply returns 0x000F.
- Random 10k pairs, both modes, random `in_valid`/`out_ready` gaps. Results are checked against a reference model, with zero dropped or duplicated transactions.
